// File: rtl/syn_fifo_fwft_pkg.sv
// Shared constants and elaboration helpers for the syn_fifo_fwft family.
package syn_fifo_fwft_pkg;

   localparam int unsigned FIFO_STD  = 0;
   localparam int unsigned FIFO_FWFT = 1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic bit params_legal(input int unsigned addr_width,
                                       input int unsigned fwft,
                                       input int unsigned afull_th,
                                       input int unsigned aempty_th);
      int unsigned depth;
      depth = 32'd1 << addr_width;
      return (afull_th >= 1) && (afull_th <= depth) && (aempty_th <= depth - 1) &&
             (fwft <= FIFO_FWFT);
   endfunction

endpackage

// File: rtl/syn_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module syn_dp_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/syn_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// fill level, threshold flags and overflow/underflow pulses.
module syn_fifo_fwft
   import syn_fifo_fwft_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned FWFT       = FIFO_STD,
   parameter int unsigned AFULL_TH   = (1 << ADDR_WIDTH) - 2,
   parameter int unsigned AEMPTY_TH  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   if (!params_legal(ADDR_WIDTH, FWFT, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
      $error("syn_fifo_fwft: FWFT, AFULL_TH or AEMPTY_TH out of range");
   end

   localparam bit                  IS_FWFT  = (FWFT == FIFO_FWFT);
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  valid_q, valid_d;
   logic                  zero_q;
   logic                  overflow_q, underflow_q;
   logic                  wr_acc, rd_acc, mem_has, ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // rd_ptr addresses the next word still in the array; in FWFT mode the
   // head may already sit in the RAM output register and is counted there.
   always_comb begin
      full         = (count_q == DEPTH_C);
      almost_full  = (count_q >= AFULL_C);
      almost_empty = (count_q <= AEMPTY_C);
      empty        = IS_FWFT ? !valid_q : (count_q == '0);
      mem_has      = (wr_ptr_q != rd_ptr_q);
      wr_acc       = wr_en & !full;
      rd_acc       = rd_en & !empty;
      ram_re       = IS_FWFT ? ((!valid_q | rd_acc) & mem_has) : (rd_acc & mem_has);
      valid_d      = IS_FWFT ? (ram_re | (valid_q & !rd_acc)) : rd_acc;
      wr_ptr_d     = wr_ptr_q + (ADDR_WIDTH+1)'(wr_acc);
      rd_ptr_d     = rd_ptr_q + (ADDR_WIDTH+1)'(ram_re);
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         zero_q      <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (sclr) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         zero_q      <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         overflow_q  <= wr_en & full;
         underflow_q <= rd_en & empty;
         if (ram_re) begin
            zero_q <= 1'b0;
         end
      end
   end

   syn_dp_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .wr_en  (wr_acc & !sclr),
      .wr_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data(din),
      .rd_en  (ram_re & !sclr),
      .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data(ram_rdata)
   );

   // The RAM output register is unreset, so mask it until the first read.
   assign dout       = zero_q ? '0 : ram_rdata;
   assign dout_valid = valid_q;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule

// File: doc/syn_fifo_fwft.md
Name: syn_fifo_fwft

Overview:
Parametrised synchronous single-clock FIFO, the next generation of the team's basic sync FIFO.
- All DEPTH entries are usable.
- Adds a selectable first-word-fall-through (FWFT) read mode and a fill-level output.
- Adds programmable almost-full/almost-empty flags, sticky-free overflow/underflow error pulses, and a synchronous clear.
- Used as the standard buffering element between streaming pipeline stages in the same clock domain.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH.
- FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- sclr, in, 1, synchronous clear; highest priority.
- wr_en, in, 1, write request.
- din, in, DATA_WIDTH, write data.
- rd_en, in, 1, read request (standard mode) / head acknowledge (FWFT mode).
- dout, out, DATA_WIDTH, read data.
- dout_valid, out, 1, dout holds a valid word (see Behaviour).
- full, out, 1, count == DEPTH.
- empty, out, 1, no word readable.
- almost_full, out, 1, threshold flag.
- almost_empty, out, 1, threshold flag.
- count, out, ADDR_WIDTH+1, words held, 0..DEPTH.
- overflow, out, 1, 1-cycle pulse: write rejected.
- underflow, out, 1, 1-cycle pulse: read rejected.

Behaviour:

Reset and clear:
- Reset is asynchronous on rst_n low.
- After reset: count=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Storage array is not reset.
- sclr=1 at an edge produces the same register state as reset. wr_en and rd_en in that cycle are ignored, and no error pulses are generated.

Accept rules:
- wr_acc = wr_en & !full.
- rd_acc = rd_en & !empty.
- Both accepted in the same cycle: count unchanged, data order preserved.
- Write while full: rejected even if a read is accepted in the same cycle. This gives simple timing, not pass-through.
- Read while empty: rejected even if a write is accepted in the same cycle.

Pointers and count:
- wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit. Pointers wrap naturally at 2*DEPTH.
- count is a registered counter: +1 on write only, -1 on read only, unchanged on both or neither.
- In FWFT mode, count includes the word held in the output stage.

Flags:
- full, almost_full and almost_empty are decoded combinationally from the registered count and pointers only; no path from wr_en or rd_en.
- Standard mode: empty = (count==0).
- FWFT mode: empty = !dout_valid.

Standard mode (FWFT=0):
- A read accepted at edge N makes dout the head word after edge N+1, and dout_valid=1 for exactly that cycle.
- dout holds its last value otherwise.

FWFT mode (FWFT=1):
- The output stage register loads from memory whenever it is empty, or is being consumed (rd_acc), and memory holds a word.
- When the output stage loads, dout_valid=1 and dout = head word.
- Write into an empty FIFO at edge N: dout_valid=1 after edge N+1.
- rd_en while dout_valid=1 consumes the head. The next word appears after the same edge if memory holds one; otherwise dout_valid drops.
- dout is stable while dout_valid=1 and rd_en=0.

Errors:
- overflow = registered (wr_en & full), i.e. high in the cycle after the rejected write.
- underflow = registered (rd_en & empty), i.e. high in the cycle after the rejected read.
- Neither is sticky.

Decomposition:
- Shared package/include holds the clog2 function, the mode constants FIFO_STD=0 and FIFO_FWFT=1, and a parameter-legality check that issues an elaboration error for out-of-range thresholds.
- One sub-module, syn_dp_ram: simple dual-port RAM with one write port and a registered read port with read enable, no reset on the array. It is reused by future async FIFO work.
- Pointer, count and flag logic and the FWFT output stage live in the top module.

Test Plan:
1. Standard mode, DEPTH=16: write 0x00..0x0F on consecutive cycles → full=1 and count=16 after the 16th edge. Then 16 reads → dout 0x00..0x0F in order, each 1 cycle after its read; empty=1 at the end.
2. Full FIFO, wr_en=1 with rd_en=1 for 1 cycle → read accepted, write rejected, count=15, overflow=1 next cycle. Empty FIFO, rd_en=1 → underflow=1 next cycle, count stays 0.
3. Simultaneous wr_en/rd_en for 40 cycles at count=5 with an incrementing pattern → count stays 5, output sequence strictly in order across pointer wrap.
4. FWFT=1: write 0xA5 into empty FIFO at edge N → dout=0xA5, dout_valid=1 after edge N+1. Hold rd_en=0 for 5 cycles → dout stable. rd_en=1 → dout_valid=0, empty=1.
5. AFULL_TH=14, AEMPTY_TH=2: fill one word at a time → almost_empty deasserts at count=3, almost_full asserts at count=14. Drain → almost_full deasserts at 13, almost_empty reasserts at 2.
6. Count=9: pulse sclr with wr_en=1 → count=0, empty=1, dout_valid=0, no overflow. Also assert rst_n low mid-burst → all outputs immediately at reset values.
